utf8_stream_decoder: RTL
========================

UTF8_STREAM_DECODER -- requirements
Module: utf8_stream_decoder

Interface
REQ-001 SHALL provide parameter ALLOW_SURR, default 0, meaning surrogate code points D800-DFFF are reported as errors when 0 and passed clean when 1.
REQ-002 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL provide port in_valid, input, 1 bit: in_data holds a byte.
REQ-005 SHALL provide port in_data, input, 8 bits: UTF-8 byte.
REQ-006 SHALL provide port in_ready, output, 1 bit: byte accepted when in_valid and in_ready are both high.
REQ-007 SHALL provide port flush, input, 1 bit: terminate any partial sequence.
REQ-008 SHALL provide port out_valid, output, 1 bit: decoded record is present.
REQ-009 SHALL provide port out_ready, input, 1 bit: consumer takes the record.
REQ-010 SHALL provide port out_cp, output, 21 bits: code point.
REQ-011 SHALL provide port out_len, output, 3 bits: input bytes consumed by this record, 1-4.
REQ-012 SHALL provide port out_err, output, 1 bit: record is malformed.
REQ-013 SHALL provide port busy, output, 1 bit: partial sequence or replay pending.
REQ-014 SHALL provide port err_count, output, 16 bits: saturating count of error records.

Function
REQ-015 SHALL use states IDLE, CONT and REPLAY, with a single output record register.
REQ-016 SHALL drive in_ready = (state!=REPLAY) && !flush && (!out_valid || out_ready).
REQ-017 SHALL classify lead bytes as follows:
- 00-7F: emit {cp=byte, len=1, err=0} immediately.
- C2-DF / E0-EF / F0-F4: go to CONT expecting 1 / 2 / 3 more bytes.
- 80-BF, C0, C1, F5-FF: emit {err=1, len=1}.
REQ-018 SHALL, in CONT, append in_data[5:0] for each accepted byte 80-BF, and emit the record when no bytes remain.
REQ-019 SHALL set err=1 on a completed record that is:
- overlong (cp below 80, 800 or 10000 for length 2, 3 or 4), or
- above 10FFFF, or
- a surrogate while ALLOW_SURR=0.
REQ-020 SHALL, when a non-continuation byte is accepted in CONT:
- emit {err=1, len=bytes consumed before it};
- latch the byte into the replay register and enter REPLAY.
REQ-021 SHALL, in REPLAY, process the latched byte as a lead byte once the output slot is free, then leave REPLAY.
REQ-022 SHALL, on flush in CONT, emit {err=1, len=bytes consumed} and go to IDLE; flush in IDLE or REPLAY has no effect.
REQ-023 SHALL give flush priority over in_valid in the same cycle; the byte is not accepted.
REQ-024 SHALL raise out_valid in the cycle after the accepting edge of the final byte (latency 1).
REQ-025 SHALL hold out_* stable while out_valid && !out_ready.
REQ-026 SHALL increment err_count on each error record handshake, saturating at FFFF.
REQ-027 SHALL hold busy = (state!=IDLE).

Reset
REQ-028 SHALL, on rst, set state=IDLE, out_valid=0, out_cp=0, out_len=0, out_err=0, err_count=0 and clear the replay register; reset mid-sequence discards the partial sequence with no record emitted.

Configuration
REQ-029 SHALL, with UTF8_STREAM_REPLACE_EN defined, output out_cp=FFFD on every error record.
REQ-030 SHALL, without UTF8_STREAM_REPLACE_EN, output on error records the partially accumulated bits, or the offending byte for single-byte errors; out_err behaves identically in both builds.

Structure
REQ-031 SHALL place the following in package utf8_pkg: the state enum, REPL_CP=21'hFFFD, MAX_CP=21'h10FFFF, the surrogate bounds and the per-length overlong minimums.
REQ-032 SHALL use one combinational sub-module, utf8_lead_classify, mapping a byte to {expected_more[1:0], is_cont, is_bad_lead, initial payload bits}.

Verification
REQ-033 SHALL cover: bytes E2 82 AC with out_ready=1 -> one record {cp=20AC, len=3, err=0}, valid one cycle after AC.
REQ-034 SHALL cover: bytes F0 9F 98 80 with out_ready held 0 for 5 cycles -> record {1F600, 4, 0} held stable; in_ready=0 throughout.
REQ-035 SHALL cover: bytes C0 AF -> two records {err=1, len=1}; err_count=2.
REQ-036 SHALL cover: bytes E2 41 -> {err=1, len=1}, then {cp=41, len=1, err=0}; busy high during REPLAY.
REQ-037 SHALL cover: bytes ED A0 80 with ALLOW_SURR=0 -> {err=1, len=3}, plus F4 90 80 80 -> {err=1, len=4}; with UTF8_STREAM_REPLACE_EN defined, cp=FFFD on both.
REQ-038 SHALL cover: byte F0 then flush, and separately byte F0 then rst -> flush yields {err=1, len=1}; rst yields no record, state=IDLE, err_count=0.

Source files
------------

// File: rtl/utf8_pkg.sv
// Shared types and constants for the UTF-8 stream decoder.
// Contents: FSM state enum, replacement/maximum code points, surrogate bounds,
// per-length overlong minimums and the completed-record validity check.
package utf8_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCont   = 2'd1,
    StReplay = 2'd2
  } state_e;

  localparam logic [20:0] REPL_CP = 21'hFFFD;
  localparam logic [20:0] MAX_CP  = 21'h10FFFF;
  localparam logic [20:0] SURR_LO = 21'hD800;
  localparam logic [20:0] SURR_HI = 21'hDFFF;
  localparam logic [20:0] MIN_CP2 = 21'h80;
  localparam logic [20:0] MIN_CP3 = 21'h800;
  localparam logic [20:0] MIN_CP4 = 21'h10000;

  // True when a fully assembled multi-byte sequence is overlong, out of range,
  // or a disallowed surrogate.
  function automatic logic cp_is_bad(logic [20:0] cp, logic [2:0] len, logic allow_surr);
    logic bad;
    bad = 1'b0;
    case (len)
      3'd2:    bad = (cp < MIN_CP2);
      3'd3:    bad = (cp < MIN_CP3);
      3'd4:    bad = (cp < MIN_CP4);
      default: bad = 1'b0;
    endcase
    if (cp > MAX_CP) bad = 1'b1;
    if (!allow_surr && (cp >= SURR_LO) && (cp <= SURR_HI)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/utf8_stream_decoder_if.sv
// Byte-in / record-out bus of the UTF-8 stream decoder.
// slave  : decoder side (consumes bytes, produces records and status).
// master : environment side (byte producer, record consumer).
// Signals: in_valid/in_data/in_ready byte handshake, flush, out_valid/out_ready
// record handshake with out_cp/out_len/out_err, busy and err_count status.
interface utf8_stream_decoder_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_cp;
  logic [2:0]  out_len;
  logic        out_err;
  logic        busy;
  logic [15:0] err_count;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_cp, out_len, out_err, busy, err_count
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_cp, out_len, out_err, busy, err_count
  );
endinterface

// File: rtl/utf8_lead_classify.sv
// Combinational classification of one UTF-8 byte.
// Ports: byte_i byte to classify; more_o continuation bytes expected after it
// as a lead; is_cont_o byte is 80-BF; bad_lead_o byte cannot start a sequence;
// payload_o data bits carried by a lead (whole byte for bad leads).
module utf8_lead_classify (
  input  logic [7:0] byte_i,
  output logic [1:0] more_o,
  output logic       is_cont_o,
  output logic       bad_lead_o,
  output logic [7:0] payload_o
);
  always_comb begin
    more_o     = 2'd0;
    is_cont_o  = 1'b0;
    bad_lead_o = 1'b0;
    payload_o  = byte_i;
    if (!byte_i[7]) begin
      payload_o = byte_i;
    end else if (byte_i[7:6] == 2'b10) begin
      is_cont_o  = 1'b1;
      bad_lead_o = 1'b1;
    end else if ((byte_i >= 8'hC2) && (byte_i <= 8'hDF)) begin
      more_o    = 2'd1;
      payload_o = {3'b000, byte_i[4:0]};
    end else if (byte_i[7:4] == 4'hE) begin
      more_o    = 2'd2;
      payload_o = {4'b0000, byte_i[3:0]};
    end else if ((byte_i >= 8'hF0) && (byte_i <= 8'hF4)) begin
      more_o    = 2'd3;
      payload_o = {5'b00000, byte_i[2:0]};
    end else begin
      // C0, C1, F5-FF
      bad_lead_o = 1'b1;
    end
  end
endmodule

// File: rtl/utf8_stream_decoder.sv
// Streaming UTF-8 decoder: one byte in per handshake, one code-point record out.
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries the
// byte handshake, flush, record handshake (out_cp/out_len/out_err), busy and a
// saturating error-record counter.
// Parameter ALLOW_SURR: 1 passes surrogates D800-DFFF as clean records.
// Build option UTF8_STREAM_REPLACE_EN: error records carry cp=FFFD instead of
// the partial bits / offending byte.
module utf8_stream_decoder
  import utf8_pkg::*;
#(
  parameter bit ALLOW_SURR = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  utf8_stream_decoder_if.slave  bus
);
  state_e      state_q, state_d;
  logic [1:0]  need_q, need_d;
  logic [2:0]  len_q, len_d;
  logic [20:0] acc_q, acc_d;
  logic [7:0]  replay_q, replay_d;
  logic        out_valid_q, out_valid_d;
  logic [20:0] out_cp_q, out_cp_d;
  logic [2:0]  out_len_q, out_len_d;
  logic        out_err_q, out_err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [7:0]  cls_byte, cls_payload;
  logic [1:0]  cls_more;
  logic        cls_is_cont, cls_bad_lead;
  logic        slot_free, in_ready, accept, lead_go;
  logic        emit, emit_err;
  logic [20:0] emit_cp, acc_next;
  logic [2:0]  emit_len;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign in_ready  = (state_q != StReplay) && !bus.flush && slot_free;
  assign accept    = bus.in_valid && in_ready;
  // In REPLAY the latched byte takes the place of the bus byte as a lead.
  assign cls_byte  = (state_q == StReplay) ? replay_q : bus.in_data;
  assign acc_next  = {acc_q[14:0], bus.in_data[5:0]};
  assign lead_go   = (state_q == StReplay) ? slot_free : accept;

  utf8_lead_classify u_classify (
    .byte_i     (cls_byte),
    .more_o     (cls_more),
    .is_cont_o  (cls_is_cont),
    .bad_lead_o (cls_bad_lead),
    .payload_o  (cls_payload)
  );

  always_comb begin
    state_d     = state_q;
    need_d      = need_q;
    len_d       = len_q;
    acc_d       = acc_q;
    replay_d    = replay_q;
    out_valid_d = out_valid_q;
    out_cp_d    = out_cp_q;
    out_len_d   = out_len_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    emit        = 1'b0;
    emit_cp     = '0;
    emit_len    = '0;
    emit_err    = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      if (out_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle, StReplay: begin
        if (lead_go) begin
          if (cls_more == 2'd0) begin
            emit     = 1'b1;
            emit_cp  = {13'd0, cls_payload};
            emit_len = 3'd1;
            emit_err = cls_bad_lead;
            state_d  = StIdle;
          end else begin
            need_d  = cls_more;
            len_d   = 3'd1;
            acc_d   = {13'd0, cls_payload};
            state_d = StCont;
          end
        end
      end
      StCont: begin
        if (bus.flush) begin
          // A pending unconsumed record blocks the flush until the slot frees.
          if (slot_free) begin
            emit     = 1'b1;
            emit_cp  = acc_q;
            emit_len = len_q;
            emit_err = 1'b1;
            state_d  = StIdle;
          end
        end else if (accept) begin
          if (cls_is_cont) begin
            if (need_q == 2'd1) begin
              emit     = 1'b1;
              emit_cp  = acc_next;
              emit_len = len_q + 3'd1;
              emit_err = cp_is_bad(acc_next, len_q + 3'd1, ALLOW_SURR);
              state_d  = StIdle;
            end else begin
              need_d = need_q - 2'd1;
              len_d  = len_q + 3'd1;
              acc_d  = acc_next;
            end
          end else begin
            emit     = 1'b1;
            emit_cp  = acc_q;
            emit_len = len_q;
            emit_err = 1'b1;
            replay_d = bus.in_data;
            state_d  = StReplay;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
`ifdef UTF8_STREAM_REPLACE_EN
      out_cp_d    = emit_err ? REPL_CP : emit_cp;
`else
      out_cp_d    = emit_cp;
`endif
      out_len_d   = emit_len;
      out_err_d   = emit_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      need_q      <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      replay_q    <= '0;
      out_valid_q <= 1'b0;
      out_cp_q    <= '0;
      out_len_q   <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      need_q      <= need_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      replay_q    <= replay_d;
      out_valid_q <= out_valid_d;
      out_cp_q    <= out_cp_d;
      out_len_q   <= out_len_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cp    = out_cp_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_err   = out_err_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.err_count = err_cnt_q;
endmodule
